// File: rtl/memoria_carregador.sv
// memoria_carregador
//   Unified word-addressed RAM placed directly behind the CPU memory
//   interface, with a byte-stream program loader that fills the RAM from
//   address 0 while holding the CPU in reset.
//
// Ports
//   clock       system clock, everything on the rising edge
//   reset       synchronous, active-high
//   mem_addr    CPU word address (MAR)
//   mem_wdata   CPU write data (MBR_out)
//   mem_rdata   registered read data (MBR_in), 1-cycle latency
//   mem_enable  CPU access strobe
//   mem_op      0 = read, 1 = write
//   load_start  pulse that begins a load (only honoured when idle)
//   load_valid  load_data carries a byte
//   load_data   loader byte
//   load_ready  loader accepts a byte this cycle (decoded from state)
//   load_busy   loader active
//   load_err    sticky error of the last load
//   cpu_reset   registered reset request to the CPU
//
// Optional feature
//   LOAD_CHECKSUM_EN : when defined, a 4-byte little-endian trailer follows
//   the data words and must equal the mod-2^32 sum of all data words.
//
// Parameters
//   ADDR_BITS : RAM depth is 2^ADDR_BITS words
//   INIT_ZERO : 1 -> RAM starts zeroed in simulation, 0 -> starts as X

module memoria_carregador #(
  parameter int unsigned ADDR_BITS = 10,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        mem_enable,
  input  logic        mem_op,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic        load_busy,
  output logic        load_err,
  output logic        cpu_reset
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_HDR  = 3'd1,
    L_DATA = 3'd2,
    L_DONE = 3'd3,
    L_SUM  = 3'd4
  } lstate_e;

  // Completes a little-endian word: asm already holds bytes 0..2.
  function automatic logic [31:0] le_word(input logic [23:0] asm, input logic [7:0] b3);
    le_word = {b3, asm};
  endfunction

  // Storage: reset never touches it, so it only has a power-on value.
  logic [31:0] ram_q [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

  lstate_e     state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] asm_q, asm_d;
  logic        err_q, err_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic [31:0] rdata_q, rdata_d;
`ifdef LOAD_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic                 ready_s;
  logic                 accept_s;
  logic                 addr_ok_s;
  logic [31:0]          word_s;
  logic                 ram_we_s;
  logic [ADDR_BITS-1:0] ram_waddr_s;
  logic [31:0]          ram_wdata_s;

  // Handshake decode and byte-assembly helpers.
  always_comb begin
`ifdef LOAD_CHECKSUM_EN
    ready_s = (state_q == L_HDR) || (state_q == L_DATA) || (state_q == L_SUM);
`else
    ready_s = (state_q == L_HDR) || (state_q == L_DATA);
`endif
    accept_s  = load_valid & ready_s;
    addr_ok_s = (mem_addr < DEPTH_W);
    word_s    = le_word(asm_q, load_data);
  end

  // Next-state, CPU port and RAM write-port decode.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    err_d       = err_q;
    cpu_reset_d = cpu_reset_q;
    rdata_d     = rdata_q;
`ifdef LOAD_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    ram_we_s    = 1'b0;
    ram_waddr_s = '0;
    ram_wdata_s = 32'h0000_0000;

    // Bytes shift in from the top so byte 0 ends up in asm[7:0] after three.
    if (accept_s) begin
      idx_d = idx_q + 2'd1;
      asm_d = {load_data, asm_q[23:8]};
    end else begin
      idx_d = idx_q;
      asm_d = asm_q;
    end

    case (state_q)
      L_IDLE: begin
        if (mem_enable && mem_op && addr_ok_s) begin
          ram_we_s    = 1'b1;
          ram_waddr_s = mem_addr[ADDR_BITS-1:0];
          ram_wdata_s = mem_wdata;
        end else if (mem_enable && !mem_op) begin
          // Out-of-range reads return zero; the address is never wrapped.
          rdata_d = addr_ok_s ? ram_q[mem_addr[ADDR_BITS-1:0]] : 32'h0000_0000;
        end else begin
          rdata_d = rdata_q;
        end
        if (load_start) begin
          state_d     = L_HDR;
          cpu_reset_d = 1'b1;
          err_d       = 1'b0;
          ptr_d       = 32'd0;
          count_d     = 32'd0;
          idx_d       = 2'd0;
`ifdef LOAD_CHECKSUM_EN
          sum_d       = 32'd0;
`endif
        end else begin
          state_d = L_IDLE;
        end
      end
      L_HDR: begin
        if (accept_s && (idx_q == 2'd3)) begin
          count_d = word_s;
          if (word_s == 32'd0) begin
`ifdef LOAD_CHECKSUM_EN
            state_d = L_SUM;
`else
            state_d = L_DONE;
`endif
          end else begin
            state_d = L_DATA;
          end
        end else begin
          state_d = L_HDR;
        end
      end
      L_DATA: begin
        if (accept_s && (idx_q == 2'd3)) begin
          // Words past the end of the RAM are consumed but dropped.
          if (ptr_q < DEPTH_W) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = ptr_q[ADDR_BITS-1:0];
            ram_wdata_s = word_s;
          end else begin
            err_d = 1'b1;
          end
          ptr_d = ptr_q + 32'd1;
`ifdef LOAD_CHECKSUM_EN
          sum_d = sum_q + word_s;
`endif
          if ((ptr_q + 32'd1) == count_q) begin
`ifdef LOAD_CHECKSUM_EN
            state_d = L_SUM;
`else
            state_d = L_DONE;
`endif
          end else begin
            state_d = L_DATA;
          end
        end else begin
          state_d = L_DATA;
        end
      end
`ifdef LOAD_CHECKSUM_EN
      L_SUM: begin
        if (accept_s && (idx_q == 2'd3)) begin
          err_d   = err_q | (word_s != sum_q);
          state_d = L_DONE;
        end else begin
          state_d = L_SUM;
        end
      end
`endif
      L_DONE: begin
        // CPU is released on the edge that leaves this state.
        state_d     = L_IDLE;
        cpu_reset_d = 1'b0;
      end
      default: begin
        state_d     = L_IDLE;
        cpu_reset_d = 1'b0;
      end
    endcase
  end

  // RAM write port; a reset edge never commits a write.
  always_ff @(posedge clock) begin
    if (ram_we_s && !reset) begin
      ram_q[ram_waddr_s] <= ram_wdata_s;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= L_IDLE;
      ptr_q       <= 32'd0;
      count_q     <= 32'd0;
      idx_q       <= 2'd0;
      asm_q       <= 24'd0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
`ifdef LOAD_CHECKSUM_EN
      sum_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      rdata_q     <= rdata_d;
`ifdef LOAD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign mem_rdata  = rdata_q;
  assign load_ready = ready_s;
  assign load_busy  = (state_q != L_IDLE);
  assign load_err   = err_q;
  assign cpu_reset  = cpu_reset_q;

endmodule

// File: tb/tb_memoria_carregador.sv
// Self-checking bench for memoria_carregador: table-driven CPU port vectors
// followed by hand-written loader sequences.

module tb_memoria_carregador;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_enable;
  logic        mem_op;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        load_busy;
  logic        load_err;
  logic        cpu_reset;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        en;
    logic        op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs[10];

  memoria_carregador #(.ADDR_BITS(10), .INIT_ZERO(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_enable (mem_enable),
    .mem_op     (mem_op),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_err   (load_err),
    .cpu_reset  (cpu_reset)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic cpu_access(input logic en, input logic op, input logic [31:0] addr,
                            input logic [31:0] wd);
    mem_enable = en;
    mem_op     = op;
    mem_addr   = addr;
    mem_wdata  = wd;
    @(negedge clock);
    mem_enable = 1'b0;
    mem_op     = 1'b0;
  endtask

  task automatic cpu_read(input string name, input logic [31:0] addr, input logic [31:0] exp);
    cpu_access(1'b1, 1'b0, addr, 32'h0);
    check(name, mem_rdata, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic start_load();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Two-word load; optionally stalls 3 cycles mid-word and pokes the CPU port.
  task automatic basic_load(input string tag, input bit stall);
    start_load();
    check({tag, "_start_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_start_busy"}, {31'd0, load_busy}, 32'd1);
    send_word(32'h0000_0002);
    send_byte(8'h44);
    send_byte(8'h33);
    if (stall) begin
      for (int i = 0; i < 3; i++) begin
        mem_enable = 1'b1;
        mem_op     = 1'b1;
        mem_addr   = 32'd9;
        mem_wdata  = 32'hFFFF_FFFF;
        @(negedge clock);
        check({tag, "_stall_ready"}, {31'd0, load_ready}, 32'd1);
        check({tag, "_stall_busy"}, {31'd0, load_busy}, 32'd1);
      end
      mem_enable = 1'b0;
      mem_op     = 1'b0;
    end
    send_byte(8'h22);
    send_byte(8'h11);
    send_word(32'h5566_7788);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'h1122_3344 + 32'h5566_7788);
`endif
    check({tag, "_done_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    check({tag, "_done_ready"}, {31'd0, load_ready}, 32'd0);
    @(negedge clock);
    check({tag, "_rel_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    check({tag, "_rel_busy"}, {31'd0, load_busy}, 32'd0);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    cpu_read({tag, "_ram0"}, 32'd0, 32'h1122_3344);
    cpu_read({tag, "_ram1"}, 32'd1, 32'h5566_7788);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] sum;

    //         en    op    addr           wdata          exp_rdata
    vecs[0] = '{1'b1, 1'b1, 32'd5,         32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'd5,         32'h0000_0000, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b0, 32'd0,         32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 32'd0,         32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 32'd7,         32'h1234_5678, 32'h0000_0000};
    vecs[7] = '{1'b1, 1'b0, 32'd7,         32'h0000_0000, 32'h1234_5678};
    vecs[8] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[9] = '{1'b1, 1'b0, 32'd5,         32'h0000_0000, 32'hDEAD_BEEF};

    reset      = 1'b1;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    mem_enable = 1'b0;
    mem_op     = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_busy", {31'd0, load_busy}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      cpu_access(vecs[i].en, vecs[i].op, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), mem_rdata, vecs[i].exp_rdata);
    end

    basic_load("load", 1'b0);

    cpu_access(1'b1, 1'b1, 32'd0, 32'h0);
    cpu_access(1'b1, 1'b1, 32'd1, 32'h0);
    basic_load("stall", 1'b1);
    cpu_read("stall_cpu_ignored", 32'd9, 32'h0);

    // Empty program: header of zero goes straight to the done state.
    start_load();
    send_word(32'h0);
`ifdef LOAD_CHECKSUM_EN
    send_word(32'h0);
`endif
    check("zero_busy", {31'd0, load_busy}, 32'd1);
    check("zero_ready", {31'd0, load_ready}, 32'd0);
    @(negedge clock);
    check("zero_rel_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("zero_err", {31'd0, load_err}, 32'd0);

    // Overflow: 1025 words into a 1024-word RAM.
    start_load();
    send_word(32'd1025);
    sum = 32'h0;
    for (int i = 0; i < 1025; i++) begin
      w = (i == 1024) ? 32'hBADB_AD00 : (32'h1000_0000 + 32'(i));
      sum = sum + w;
      send_word(w);
      if (i == 1023) check("ovf_err_before_last", {31'd0, load_err}, 32'd0);
    end
`ifdef LOAD_CHECKSUM_EN
    send_word(sum);
`endif
    check("ovf_err", {31'd0, load_err}, 32'd1);
    @(negedge clock);
    check("ovf_idle", {31'd0, load_busy}, 32'd0);
    check("ovf_err_sticky", {31'd0, load_err}, 32'd1);
    cpu_read("ovf_ram0", 32'd0, 32'h1000_0000);
    cpu_read("ovf_ram1023", 32'd1023, 32'h1000_03FF);

    // Reset part-way through the first data word.
    start_load();
    send_word(32'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, load_busy}, 32'd0);
    check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("abort_ready", {31'd0, load_ready}, 32'd0);
    check("abort_rdata", mem_rdata, 32'h0);
    cpu_read("abort_ram0", 32'd0, 32'h1000_0000);
    cpu_read("abort_ram1", 32'd1, 32'h1000_0001);

`ifdef LOAD_CHECKSUM_EN
    start_load();
    send_word(32'd1);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    check("sum_bad_err", {31'd0, load_err}, 32'd1);
    @(negedge clock);
    start_load();
    send_word(32'd1);
    send_word(32'h0000_0001);
    send_word(32'h0000_0001);
    check("sum_good_err", {31'd0, load_err}, 32'd0);
    @(negedge clock);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memoria_carregador.md
Name: memoria_carregador

Overview:
- Unified word-addressed RAM that sits directly downstream of the CPU memory interface. It serves the CPU's MAR/MBR_out/mem_enable/mem_op accesses with a fixed 1-cycle read latency.
- Contains a program-loader FSM. The loader takes a byte stream over a valid/ready handshake, assembles little-endian words into RAM from address 0, and holds the CPU in reset while loading.

Parameters:
- ADDR_BITS, 10, RAM depth = 2^ADDR_BITS words (DEPTH).
- INIT_ZERO, 1, if 1 the RAM contents are zero at simulation start; if 0 they are X.

Ports:
- clock  in  1  system clock, all logic on its rising edge
- reset  in  1  synchronous, active-high
- mem_addr  in  32  word address (CPU MAR)
- mem_wdata  in  32  write data (CPU MBR_out)
- mem_rdata  out  32  read data (CPU MBR_in), registered
- mem_enable  in  1  1 = access active this cycle
- mem_op  in  1  0 = read, 1 = write
- load_start  in  1  pulse: begin a load
- load_valid  in  1  load_data holds a valid byte
- load_data  in  8  loader byte
- load_ready  out  1  loader accepts a byte this cycle
- load_busy  out  1  loader active
- load_err  out  1  sticky error flag of the last load
- cpu_reset  out  1  registered reset request to the CPU

Behaviour:
- Reset values:
  - mem_rdata = 0, load_ready = 0, load_busy = 0, load_err = 0, cpu_reset = 0.
  - Loader FSM goes to L_IDLE; word pointer, byte index and count are cleared.
  - RAM contents are NOT modified by reset. A reset in the middle of a load aborts it and leaves the words already written in place.
- CPU port, active only when the loader is in L_IDLE:
  - Read: at edge k with mem_enable = 1 and mem_op = 0, mem_rdata <= RAM[mem_addr]. The data is valid through cycle k+1 and is held until the next read.
  - Write: at edge k with mem_enable = 1 and mem_op = 1, RAM[mem_addr] <= mem_wdata. mem_rdata is unchanged.
  - Out of range (mem_addr >= DEPTH): a read returns 0 and a write is ignored. The address is never wrapped.
  - mem_enable = 0: no RAM change, mem_rdata held.
  - While the loader is not in L_IDLE, CPU accesses are ignored and mem_rdata is held.
- Loader FSM states: L_IDLE, L_HDR, L_DATA, L_DONE. A byte is accepted only on an edge where load_valid = 1 and load_ready = 1.
- L_IDLE:
  - load_start = 1 -> go to L_HDR. At the same edge cpu_reset <= 1, load_err <= 0, pointer <= 0, byte index <= 0.
  - load_start is ignored in every other state.
- L_HDR:
  - load_ready = 1.
  - Four bytes arrive little-endian and form count[31:0].
  - After the 4th byte: count = 0 -> L_DONE; otherwise -> L_DATA.
- L_DATA:
  - load_ready = 1.
  - Bytes assemble little-endian: byte 0 goes to [7:0], byte 3 to [31:24].
  - On the edge that accepts the 4th byte, the word is written to RAM[pointer] in the same cycle and pointer increments.
  - If pointer >= DEPTH, the word is discarded (not written), load_err <= 1, and the stream is still consumed.
  - When pointer reaches count -> L_DONE.
  - A gap with load_valid = 0 only stalls the FSM; no timeout.
- L_DONE:
  - load_ready = 0, stays for 1 cycle, then -> L_IDLE.
  - cpu_reset <= 0 on the edge leaving L_DONE, so the CPU is released one cycle after the last write.
- load_busy = 1 in L_HDR, L_DATA and L_DONE.
- load_ready is combinational from the state (1 only in L_HDR and L_DATA).
- Count arithmetic: count and pointer are 32-bit unsigned; pointer compares against count, not DEPTH.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- Defined:
  - An extra state L_SUM follows L_DATA, or follows L_HDR when count = 0.
  - L_SUM accepts 4 more little-endian bytes forming a 32-bit trailer.
  - The running sum (mod 2^32) covers all received data words, including discarded ones.
  - trailer != sum -> load_err <= 1. Then -> L_DONE.
- Undefined: no trailer is expected; load_err reports overflow only.

Test Plan:
- Reset, then a CPU write of 0xDEADBEEF to address 5, then a read of 5 -> mem_rdata = 0xDEADBEEF exactly one cycle after the read edge. A read of 0x400 (DEPTH 1024) -> mem_rdata = 0.
- load_start, header 02 00 00 00, data 44 33 22 11 88 77 66 55 -> RAM[0] = 0x11223344 and RAM[1] = 0x55667788. cpu_reset is 1 from the start edge until one cycle after the last byte; load_err = 0.
- Same load with load_valid deasserted for 3 cycles in the middle of a word -> identical RAM result. load_ready stays 1 and the FSM is stalled.
- Header with count = 1025 and 1025 words streamed -> RAM[0..1023] written, load_err = 1, RAM[0] not overwritten by word 1024, FSM returns to L_IDLE.
- Reset asserted after 3 data bytes -> load_busy = 0, cpu_reset = 0, previous RAM contents intact, and a later CPU read of 0 returns the old value.
- With LOAD_CHECKSUM_EN: count = 1, word 0x00000001, trailer 0x00000002 -> load_err = 1. Trailer 0x00000001 -> load_err = 0.
